// File: rtl/tracer_pkg.sv
// rtl/tracer_pkg.sv - shared constants for the tracer frame sequencer
package tracer_pkg;

  localparam int DEF_N_ELEM       = 64;
  localparam int DEF_CONTOUR_BITS = 256;
  localparam int DEF_DRAIN_CYCLES = 16;
  localparam int DEF_TRACE_W      = 16;
  localparam int DEF_CNT_W        = 15;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CENTER  = 3'd1;
  localparam logic [2:0] ST_CONTOUR = 3'd2;
  localparam logic [2:0] ST_COMMIT  = 3'd3;
  localparam logic [2:0] ST_STREAM  = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;
  localparam logic [2:0] ST_READOUT = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

endpackage

// File: rtl/tracer_seq_counter.sv
// rtl/tracer_seq_counter.sv - clearable up-counter with terminal-count flag
module tracer_seq_counter
  import tracer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  // Clear has priority so a state change always restarts the count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/tracer_frame_sequencer.sv
// rtl/tracer_frame_sequencer.sv - per-frame control sequencer for the tracer segment chain
module tracer_frame_sequencer
  import tracer_pkg::*;
#(
  parameter int N_ELEM       = DEF_N_ELEM,
  parameter int CONTOUR_BITS = DEF_CONTOUR_BITS,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int TRACE_W      = DEF_TRACE_W,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_aresetn,
  input  logic               start,
  input  logic               abort,
  output logic               load_center,
  output logic               contour_rden,
  output logic [CNT_W-1:0]   contour_addr,
  output logic               load_contour,
  output logic               stream_go,
  input  logic               stream_last,
  output logic               store_trace,
  input  logic [TRACE_W-1:0] acc_trace_in,
  output logic               m_trace_valid,
  output logic [TRACE_W-1:0] m_trace_data,
  input  logic               m_trace_ready,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(N_ELEM * CONTOUR_BITS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(N_ELEM);

  logic [2:0]       state;
  logic [2:0]       nxt;
  logic             clr;
  logic             hs;
  logic             addr_tc;
  logic             drain_tc;
  logic             word_tc;
  logic [CNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic             unused_cnt_bits;

  assign hs  = (state == ST_READOUT) && m_trace_valid && m_trace_ready;
  assign clr = abort || (nxt != state);
  assign unused_cnt_bits = ^{drain_cnt, word_cnt};

  tracer_seq_counter #(.CNT_W(CNT_W)) u_addr_cnt (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .clr   (clr),
    .inc   (state == ST_CONTOUR),
    .last  (ADDR_LAST),
    .count (contour_addr),
    .tc    (addr_tc)
  );

  tracer_seq_counter #(.CNT_W(CNT_W)) u_drain_cnt (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .clr   (clr),
    .inc   (state == ST_DRAIN),
    .last  (DRAIN_LAST),
    .count (drain_cnt),
    .tc    (drain_tc)
  );

  // Word count reaches N_ELEM in the store_trace cycle after the last handshake.
  tracer_seq_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .clr   (clr),
    .inc   (hs),
    .last  (WORD_LAST),
    .count (word_cnt),
    .tc    (word_tc)
  );

  // Next-state selection; abort overrides every transition including start.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (start) nxt = ST_CENTER;
      ST_CENTER:  nxt = ST_CONTOUR;
      ST_CONTOUR: if (addr_tc) nxt = ST_COMMIT;
      ST_COMMIT:  nxt = ST_STREAM;
      ST_STREAM:  if (stream_last) nxt = ST_DRAIN;
      ST_DRAIN:   if (drain_tc) nxt = ST_READOUT;
      ST_READOUT: if (store_trace && word_tc) nxt = ST_DONE;
      ST_DONE:    nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
    if (abort) nxt = ST_IDLE;
  end

  // State and all outputs are registered from the next state so strobes align with state residency.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= ST_IDLE;
      load_center   <= 1'b0;
      contour_rden  <= 1'b0;
      load_contour  <= 1'b0;
      stream_go     <= 1'b0;
      store_trace   <= 1'b0;
      m_trace_valid <= 1'b0;
      m_trace_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state        <= nxt;
      load_center  <= (nxt == ST_CENTER);
      contour_rden <= (nxt == ST_CONTOUR);
      load_contour <= (nxt == ST_COMMIT);
      stream_go    <= (nxt == ST_STREAM);
      busy         <= (nxt != ST_IDLE);
      done         <= (nxt == ST_DONE);
      store_trace  <= hs && !abort;
      if (nxt != ST_READOUT) begin
        m_trace_valid <= 1'b0;
        m_trace_data  <= '0;
      end else if (hs) begin
        m_trace_valid <= 1'b0;
      end else if (!m_trace_valid && state == ST_READOUT) begin
        m_trace_valid <= 1'b1;
        m_trace_data  <= acc_trace_in;
      end
    end
  end

endmodule
